// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: states, opcodes,
// status codes and packet field positions.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_RUN   = 8'h03;

    localparam logic [1:0] STATUS_OK         = 2'b00;
    localparam logic [1:0] STATUS_ENGINE_ERR = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT    = 2'b10;
    localparam logic [1:0] STATUS_ILLEGAL    = 2'b11;

    localparam int unsigned OPCODE_LSB  = 120;
    localparam int unsigned OPCODE_W    = 8;
    localparam int unsigned TARGET_LSB  = 112;
    localparam int unsigned TARGET_W    = 8;
    localparam int unsigned SEQ_LSB     = 96;
    localparam int unsigned SEQ_W       = 16;
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned PAYLOAD_W   = 96;

    function automatic logic opcode_legal(input logic [7:0] op);
        return (op == OP_NOP) || (op == OP_WRITE) || (op == OP_READ) || (op == OP_RUN);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// ISSUE-state watchdog: counts enabled cycles and flags the last allowed one.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // expired marks the final permitted cycle so the owner leaves after exactly TIMEOUT_CYCLES
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Takes 16-byte packets from the UART receiver, validates them, presents legal
// commands to the tester engine and records completion status and counts.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned NUM_TARGETS    = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RX_DATA_READY,
    input  logic [127:0] RX_DATA,
    output logic         RX_DATA_RETRIEVED,
    output logic         CMD_VALID,
    output logic [7:0]   CMD_OPCODE,
    output logic [1:0]   CMD_TARGET,
    output logic [15:0]  CMD_SEQ,
    output logic [95:0]  CMD_PAYLOAD,
    input  logic         CMD_DONE,
    input  logic         CMD_ERR,
    output logic         BUSY,
    output logic [1:0]   LAST_STATUS,
    output logic [15:0]  CMD_COUNT,
    output logic [7:0]   ERR_COUNT
);

    state_t       state;
    logic [127:0] pkt;
    logic [1:0]   status;
    logic         timer_clear;
    logic         timer_enable;
    logic         timer_expired;
    logic [7:0]   pkt_opcode;
    logic [7:0]   pkt_target;
    logic         pkt_legal;

    assign pkt_opcode = pkt[OPCODE_LSB +: OPCODE_W];
    assign pkt_target = pkt[TARGET_LSB +: TARGET_W];
    // the whole target byte is compared so any high bit makes it illegal
    assign pkt_legal  = opcode_legal(pkt_opcode) && ({24'd0, pkt_target} < NUM_TARGETS);

    assign timer_clear  = (state == S_DECODE);
    assign timer_enable = (state == S_ISSUE);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= S_IDLE;
            pkt               <= '0;
            status            <= STATUS_OK;
            RX_DATA_RETRIEVED <= 1'b0;
            CMD_VALID         <= 1'b0;
            CMD_OPCODE        <= '0;
            CMD_TARGET        <= '0;
            CMD_SEQ           <= '0;
            CMD_PAYLOAD       <= '0;
            BUSY              <= 1'b0;
            LAST_STATUS       <= '0;
            CMD_COUNT         <= '0;
            ERR_COUNT         <= '0;
        end else begin
            RX_DATA_RETRIEVED <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (RX_DATA_READY) begin
                        pkt               <= RX_DATA;
                        RX_DATA_RETRIEVED <= 1'b1;
                        BUSY              <= 1'b1;
                        state             <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!pkt_legal) begin
                        status <= STATUS_ILLEGAL;
                        state  <= S_RESULT;
                    end else if (pkt_opcode == OP_NOP) begin
                        status <= STATUS_OK;
                        state  <= S_RESULT;
                    end else begin
                        CMD_VALID   <= 1'b1;
                        CMD_OPCODE  <= pkt_opcode;
                        CMD_TARGET  <= pkt_target[1:0];
                        CMD_SEQ     <= pkt[SEQ_LSB +: SEQ_W];
                        CMD_PAYLOAD <= pkt[PAYLOAD_LSB +: PAYLOAD_W];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // completion takes priority over a coincident watchdog expiry
                    if (CMD_DONE) begin
                        status    <= {1'b0, CMD_ERR};
                        CMD_VALID <= 1'b0;
                        state     <= S_RESULT;
                    end else if (timer_expired) begin
                        status    <= STATUS_TIMEOUT;
                        CMD_VALID <= 1'b0;
                        state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    LAST_STATUS <= status;
                    if (status == STATUS_OK) begin
                        if (CMD_COUNT != '1) CMD_COUNT <= CMD_COUNT + 1'b1;
                    end else begin
                        if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
                    end
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized and directed checks of uart_cmd_sequencer against a transaction-level model.
module tb_uart_cmd_sequencer;

    localparam int TO = 16;
    localparam int NT = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         RX_DATA_READY = 1'b0;
    logic [127:0] RX_DATA = '0;
    logic         RX_DATA_RETRIEVED;
    logic         CMD_VALID;
    logic [7:0]   CMD_OPCODE;
    logic [1:0]   CMD_TARGET;
    logic [15:0]  CMD_SEQ;
    logic [95:0]  CMD_PAYLOAD;
    logic         CMD_DONE = 1'b0;
    logic         CMD_ERR = 1'b0;
    logic         BUSY;
    logic [1:0]   LAST_STATUS;
    logic [15:0]  CMD_COUNT;
    logic [7:0]   ERR_COUNT;

    uart_cmd_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .NUM_TARGETS(NT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_DATA_READY(RX_DATA_READY), .RX_DATA(RX_DATA),
        .RX_DATA_RETRIEVED(RX_DATA_RETRIEVED),
        .CMD_VALID(CMD_VALID), .CMD_OPCODE(CMD_OPCODE), .CMD_TARGET(CMD_TARGET),
        .CMD_SEQ(CMD_SEQ), .CMD_PAYLOAD(CMD_PAYLOAD),
        .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR),
        .BUSY(BUSY), .LAST_STATUS(LAST_STATUS),
        .CMD_COUNT(CMD_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Model: transaction phase (0 waiting, 1 validating, 2 engine busy, 3 reporting)
    int           m_phase = 0;
    int           m_age = 0;
    logic [127:0] m_pkt = '0;
    logic [1:0]   m_status = '0;
    logic         e_ret = 0, e_valid = 0, e_busy = 0;
    logic [7:0]   e_op = '0;
    logic [1:0]   e_tgt = '0;
    logic [15:0]  e_seq = '0;
    logic [95:0]  e_pay = '0;
    logic [1:0]   e_last = '0;
    int           e_cnt = 0;
    int           e_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_phase = 0; e_ret = 0; e_valid = 0; e_busy = 0;
            e_op = '0; e_tgt = '0; e_seq = '0; e_pay = '0;
            e_last = '0; e_cnt = 0; e_err = 0;
        end else begin
            e_ret = 0;
            case (m_phase)
                0: if (RX_DATA_READY) begin
                    m_pkt = RX_DATA; e_ret = 1; m_phase = 1;
                end
                1: begin
                    int op, tg;
                    op = int'(m_pkt[127:120]);
                    tg = int'(m_pkt[119:112]);
                    if (op > 3 || tg >= NT) begin
                        m_status = 2'b11; m_phase = 3;
                    end else if (op == 0) begin
                        m_status = 2'b00; m_phase = 3;
                    end else begin
                        m_phase = 2; m_age = 0; e_valid = 1;
                        e_op = m_pkt[127:120]; e_tgt = m_pkt[113:112];
                        e_seq = m_pkt[111:96]; e_pay = m_pkt[95:0];
                    end
                end
                2: begin
                    m_age++;
                    if (CMD_DONE) begin
                        m_status = {1'b0, CMD_ERR}; m_phase = 3; e_valid = 0;
                    end else if (m_age == TO) begin
                        m_status = 2'b10; m_phase = 3; e_valid = 0;
                    end
                end
                default: begin
                    e_last = m_status;
                    if (m_status == 2'b00) e_cnt = (e_cnt < 65535) ? e_cnt + 1 : 65535;
                    else e_err = (e_err < 255) ? e_err + 1 : 255;
                    m_phase = 0;
                end
            endcase
            e_busy = (m_phase != 0);
        end
    endtask

    // One clock: inputs already driven, sample #1 after the edge, advance model, compare.
    task automatic step();
        @(posedge CLK);
        #1;
        model_step();
        check("retrieved", 128'(RX_DATA_RETRIEVED), 128'(e_ret));
        check("cmd_valid", 128'(CMD_VALID), 128'(e_valid));
        check("busy", 128'(BUSY), 128'(e_busy));
        check("last_status", 128'(LAST_STATUS), 128'(e_last));
        check("cmd_count", 128'(CMD_COUNT), 128'(e_cnt));
        check("err_count", 128'(ERR_COUNT), 128'(e_err));
        if (e_valid || RST) begin
            check("opcode", 128'(CMD_OPCODE), 128'(e_op));
            check("target", 128'(CMD_TARGET), 128'(e_tgt));
            check("seq", 128'(CMD_SEQ), 128'(e_seq));
            check("payload", 128'(CMD_PAYLOAD), 128'(e_pay));
        end
    endtask

    function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] tg,
                                        input logic [15:0] seq, input logic [95:0] pay);
        return {op, tg, seq, pay};
    endfunction

    // Present a packet, then answer with CMD_DONE in engine cycle done_at (0 = first CMD_VALID cycle).
    task automatic send(input logic [127:0] pkt, input int done_at, input logic err_v,
                        output int valid_cycles, output int ret_pulses, output int first_valid);
        valid_cycles = 0; ret_pulses = 0; first_valid = -1;
        CMD_DONE = 0; CMD_ERR = 0;
        RX_DATA = pkt; RX_DATA_READY = 1;
        step();
        if (RX_DATA_RETRIEVED) ret_pulses++;
        RX_DATA_READY = 0;
        for (int c = 0; c < 40; c++) begin
            CMD_DONE = (c - 1 == done_at);
            CMD_ERR = err_v & CMD_DONE;
            step();
            if (RX_DATA_RETRIEVED) ret_pulses++;
            if (CMD_VALID) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = c;
            end
            if (m_phase == 0) break;
        end
        CMD_DONE = 0; CMD_ERR = 0;
        step();
    endtask

    initial begin
        int vc, rp, fv;
        RST = 1;
        repeat (3) step();
        check("reset_busy_lit", 128'(BUSY), 128'(0));
        RST = 0;
        step();

        // WRITE, target 1, seq 5, done three cycles after CMD_VALID
        send(mk(8'h01, 8'h01, 16'h0005, 96'hA5A5_0000_1111_2222_3333_4444), 3, 0, vc, rp, fv);
        check("w_ret_pulses_lit", 128'(rp), 128'(1));
        check("w_first_valid_lit", 128'(fv), 128'(0));
        check("w_valid_cycles_lit", 128'(vc), 128'(4));
        check("w_status_lit", 128'(LAST_STATUS), 128'(2'b00));
        check("w_count_lit", 128'(CMD_COUNT), 128'(1));

        send(mk(8'h7F, 8'h00, 16'h0006, 96'h0), 100, 0, vc, rp, fv);
        check("badop_valid_lit", 128'(vc), 128'(0));
        check("badop_status_lit", 128'(LAST_STATUS), 128'(2'b11));
        check("badop_err_lit", 128'(ERR_COUNT), 128'(1));
        send(mk(8'h02, 8'h04, 16'h0007, 96'h0), 100, 0, vc, rp, fv);
        check("badtgt_valid_lit", 128'(vc), 128'(0));
        check("badtgt_err_lit", 128'(ERR_COUNT), 128'(2));
        send(mk(8'h01, 8'h41, 16'h0008, 96'h0), 100, 0, vc, rp, fv);
        check("hitgt_err_lit", 128'(ERR_COUNT), 128'(3));

        send(mk(8'h03, 8'h03, 16'h0009, 96'h1234), 100, 0, vc, rp, fv);
        check("to_valid_cycles_lit", 128'(vc), 128'(16));
        check("to_status_lit", 128'(LAST_STATUS), 128'(2'b10));

        send(mk(8'h03, 8'h02, 16'h000A, 96'h5678), 15, 0, vc, rp, fv);
        check("tie_valid_cycles_lit", 128'(vc), 128'(16));
        check("tie_status_lit", 128'(LAST_STATUS), 128'(2'b00));
        send(mk(8'h02, 8'h00, 16'h000B, 96'h9ABC), 0, 1, vc, rp, fv);
        check("eng_err_status_lit", 128'(LAST_STATUS), 128'(2'b01));

        // Reset while the engine holds a command; receiver keeps its packet
        RX_DATA = mk(8'h03, 8'h01, 16'h000C, 96'hDEAD); RX_DATA_READY = 1;
        step();
        RX_DATA_READY = 0;
        repeat (4) step();
        check("pre_rst_valid_lit", 128'(CMD_VALID), 128'(1));
        RST = 1; RX_DATA_READY = 1;
        step();
        check("rst_valid_lit", 128'(CMD_VALID), 128'(0));
        check("rst_cnt_lit", 128'(CMD_COUNT), 128'(0));
        check("rst_err_lit", 128'(ERR_COUNT), 128'(0));
        RST = 0;
        step();
        check("reaccept_lit", 128'(RX_DATA_RETRIEVED), 128'(1));
        RX_DATA_READY = 0;
        for (int i = 0; i < 30 && m_phase != 0; i++) begin
            CMD_DONE = (m_phase == 2);
            step();
        end
        CMD_DONE = 0;
        step();

        RST = 1; step(); RST = 0; step();
        for (int i = 0; i < 300; i++) send(mk(8'h00, 8'h00, 16'(i), 96'h0), 100, 0, vc, rp, fv);
        check("count300_lit", 128'(CMD_COUNT), 128'(300));
        for (int i = 0; i < 260; i++) send(mk(8'hC0, 8'h00, 16'(i), 96'h0), 100, 0, vc, rp, fv);
        check("errsat_lit", 128'(ERR_COUNT), 128'(8'hFF));
        check("count_kept_lit", 128'(CMD_COUNT), 128'(300));

        // Random traffic, including stray CMD_DONE and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] op, tg;
            op = 8'($urandom_range(0, 5));
            if (op > 3) op = 8'($urandom_range(4, 255));
            tg = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
            RST = ($urandom_range(0, 199) == 0);
            RX_DATA_READY = ($urandom_range(0, 2) != 0);
            RX_DATA = {op, tg, 16'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            CMD_DONE = ($urandom_range(0, 15) == 0);
            CMD_ERR = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
